// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM cash dispenser: FSM states, note codes,
// note values and failure codes.
package atm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StPlan,
    StDispense,
    StFinish,
    StFail
  } state_e;

  localparam logic [1:0] DEN_NONE = 2'b00;
  localparam logic [1:0] DEN_100  = 2'b01;
  localparam logic [1:0] DEN_500  = 2'b10;
  localparam logic [1:0] DEN_2000 = 2'b11;

  localparam int unsigned VAL_100  = 100;
  localparam int unsigned VAL_500  = 500;
  localparam int unsigned VAL_2000 = 2000;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_AMOUNT = 2'b01;
  localparam logic [1:0] ERR_STOCK  = 2'b10;

endpackage

// File: rtl/atm_cash_dispenser_if.sv
// Controller/feeder side of the dispenser: request, note handshake, status and stock.
interface atm_cash_dispenser_if #(
  parameter int unsigned AMT_W = 16,
  parameter int unsigned CNT_W = 8
) ();

  logic             start;
  logic [AMT_W-1:0] amount;
  logic             note_ack;
  logic             note_valid;
  logic [1:0]       note_denom;
  logic             busy;
  logic             done;
  logic             error;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] stock_2000;
  logic [CNT_W-1:0] stock_500;
  logic [CNT_W-1:0] stock_100;

  modport master (
    output start, amount, note_ack,
    input  note_valid, note_denom, busy, done, error, err_code,
    input  stock_2000, stock_500, stock_100
  );

  modport slave (
    input  start, amount, note_ack,
    output note_valid, note_denom, busy, done, error, err_code,
    output stock_2000, stock_500, stock_100
  );

endinterface

// File: rtl/atm_cassette.sv
// One note cassette: stock counter reloaded on reset, decremented per accepted note.
module atm_cassette #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned INIT  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= CNT_W'(INIT);
    end else if (dec_i) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/atm_cash_dispenser.sv
// Plans a greedy note breakdown against cassette stock, then feeds notes one at a
// time over valid/ack and reports done or a coded failure.
module atm_cash_dispenser
  import atm_pkg::*;
#(
  parameter int unsigned AMT_W     = 16,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_AMT   = 20000,
  parameter int unsigned INIT_2000 = 20,
  parameter int unsigned INIT_500  = 40,
  parameter int unsigned INIT_100  = 100
) (
  input  logic clock,
  input  logic reset,
  atm_cash_dispenser_if.slave bus
);

  state_e           state_q;
  logic [AMT_W-1:0] rem_q;
  logic [CNT_W-1:0] p2000_q, p500_q, p100_q;
  logic             note_valid_q;
  logic [1:0]       note_denom_q;
  logic             busy_q, done_q, error_q;
  logic [1:0]       err_code_q;

  logic [CNT_W-1:0] stock_2000, stock_500, stock_100;
  logic             ack_fire, dec_2000, dec_500, dec_100;
  logic [CNT_W-1:0] p2000_nx, p500_nx, p100_nx;
  logic             any_left;
  logic [1:0]       next_denom;

  // Plan counts after this cycle's handshake; decide what is presented next.
  always_comb begin
    ack_fire   = note_valid_q & bus.note_ack;
    dec_2000   = ack_fire && (note_denom_q == DEN_2000);
    dec_500    = ack_fire && (note_denom_q == DEN_500);
    dec_100    = ack_fire && (note_denom_q == DEN_100);
    p2000_nx   = p2000_q - CNT_W'(dec_2000);
    p500_nx    = p500_q - CNT_W'(dec_500);
    p100_nx    = p100_q - CNT_W'(dec_100);
    any_left   = (p2000_nx != '0) || (p500_nx != '0) || (p100_nx != '0);
    next_denom = DEN_NONE;
    if (p2000_nx != '0) begin
      next_denom = DEN_2000;
    end else if (p500_nx != '0) begin
      next_denom = DEN_500;
    end else if (p100_nx != '0) begin
      next_denom = DEN_100;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      rem_q        <= '0;
      p2000_q      <= '0;
      p500_q       <= '0;
      p100_q       <= '0;
      note_valid_q <= 1'b0;
      note_denom_q <= DEN_NONE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            rem_q      <= bus.amount;
            p2000_q    <= '0;
            p500_q     <= '0;
            p100_q     <= '0;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b1;
            state_q    <= StCheck;
          end
        end
        StCheck: begin
          if (rem_q == '0 || rem_q > AMT_W'(MAX_AMT)) begin
            err_code_q <= ERR_AMOUNT;
            error_q    <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StFail;
          end else begin
            state_q <= StPlan;
          end
        end
        StPlan: begin
          if (rem_q >= AMT_W'(VAL_2000) && p2000_q < stock_2000) begin
            p2000_q <= p2000_q + CNT_W'(1);
            rem_q   <= rem_q - AMT_W'(VAL_2000);
          end else if (rem_q >= AMT_W'(VAL_500) && p500_q < stock_500) begin
            p500_q <= p500_q + CNT_W'(1);
            rem_q  <= rem_q - AMT_W'(VAL_500);
          end else if (rem_q >= AMT_W'(VAL_100) && p100_q < stock_100) begin
            p100_q <= p100_q + CNT_W'(1);
            rem_q  <= rem_q - AMT_W'(VAL_100);
          end else if (rem_q == '0) begin
            if (any_left) begin
              note_valid_q <= 1'b1;
              note_denom_q <= next_denom;
              state_q      <= StDispense;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StFinish;
            end
          end else begin
            // Sub-100 residue means the amount itself is bad, otherwise stock ran out.
            err_code_q <= (rem_q < AMT_W'(VAL_100)) ? ERR_AMOUNT : ERR_STOCK;
            error_q    <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StFail;
          end
        end
        StDispense: begin
          p2000_q <= p2000_nx;
          p500_q  <= p500_nx;
          p100_q  <= p100_nx;
          if (any_left) begin
            note_denom_q <= next_denom;
          end else begin
            note_valid_q <= 1'b0;
            note_denom_q <= DEN_NONE;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= StFinish;
          end
        end
        StFinish: state_q <= StIdle;
        StFail:   state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  atm_cassette #(.CNT_W(CNT_W), .INIT(INIT_2000)) u_cas_2000 (
    .clock   (clock),
    .reset   (reset),
    .dec_i   (dec_2000),
    .count_o (stock_2000)
  );

  atm_cassette #(.CNT_W(CNT_W), .INIT(INIT_500)) u_cas_500 (
    .clock   (clock),
    .reset   (reset),
    .dec_i   (dec_500),
    .count_o (stock_500)
  );

  atm_cassette #(.CNT_W(CNT_W), .INIT(INIT_100)) u_cas_100 (
    .clock   (clock),
    .reset   (reset),
    .dec_i   (dec_100),
    .count_o (stock_100)
  );

  assign bus.note_valid = note_valid_q;
  assign bus.note_denom = note_denom_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.err_code   = err_code_q;
  assign bus.stock_2000 = stock_2000;
  assign bus.stock_500  = stock_500;
  assign bus.stock_100  = stock_100;

endmodule

// File: tb/tb_atm_cash_dispenser.sv
// Bench for atm_cash_dispenser: vector table of transactions with a note scoreboard,
// plus reset and mid-transaction abort sequences.
module tb_atm_cash_dispenser;
  import atm_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  atm_cash_dispenser_if #(.AMT_W(16), .CNT_W(8)) ia ();
  atm_cash_dispenser_if #(.AMT_W(16), .CNT_W(8)) ib ();

  atm_cash_dispenser dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ia)
  );

  atm_cash_dispenser #(.INIT_2000(0), .INIT_500(1), .INIT_100(2)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ib)
  );

  typedef struct {
    bit          use_b;
    logic [15:0] amount;
    int          hold;
    bit          poke;
    int          exp_err;
    logic [1:0]  exp_code;
    int          n2000, n500, n100;
    int          s2000, s500, s100;
  } vec_t;

  vec_t       vecs[8];
  int         total = 0;
  int         bad = 0;
  bit         sel_b = 1'b0;
  logic [1:0] exp_q[$];

  logic       s_valid, s_busy, s_done, s_error;
  logic [1:0] s_denom, s_code;
  logic [7:0] s_s2000, s_s500, s_s100;

  always_comb begin
    if (sel_b) begin
      s_valid = ib.note_valid; s_busy = ib.busy; s_done = ib.done; s_error = ib.error;
      s_denom = ib.note_denom; s_code = ib.err_code;
      s_s2000 = ib.stock_2000; s_s500 = ib.stock_500; s_s100 = ib.stock_100;
    end else begin
      s_valid = ia.note_valid; s_busy = ia.busy; s_done = ia.done; s_error = ia.error;
      s_denom = ia.note_denom; s_code = ia.err_code;
      s_s2000 = ia.stock_2000; s_s500 = ia.stock_500; s_s100 = ia.stock_100;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic st, input logic [15:0] amt, input logic ack);
    if (sel_b) begin
      ib.start = st; ib.amount = amt; ib.note_ack = ack;
    end else begin
      ia.start = st; ia.amount = amt; ia.note_ack = ack;
    end
  endtask

  task automatic check_idle_outputs(input string tag, input int s2, input int s5, input int s1);
    check({tag, "_valid"}, s_valid, 0);
    check({tag, "_denom"}, s_denom, 0);
    check({tag, "_busy"}, s_busy, 0);
    check({tag, "_done"}, s_done, 0);
    check({tag, "_error"}, s_error, 0);
    check({tag, "_code"}, s_code, 0);
    check({tag, "_s2000"}, s_s2000, s2);
    check({tag, "_s500"}, s_s500, s5);
    check({tag, "_s100"}, s_s100, s1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         nd, ne, held, first, last, acc;
    bit         fin;
    logic [1:0] e;
    logic [1:0] first_den;
    sel_b = v.use_b;
    for (int i = 0; i < v.n2000; i++) exp_q.push_back(DEN_2000);
    for (int i = 0; i < v.n500; i++) exp_q.push_back(DEN_500);
    for (int i = 0; i < v.n100; i++) exp_q.push_back(DEN_100);
    first_den = (exp_q.size() > 0) ? exp_q[0] : DEN_NONE;
    nd = 0; ne = 0; held = 0; first = -1; last = -1; acc = 0; fin = 1'b0;

    @(negedge clock);
    drive(1'b1, v.amount, v.hold == 0);
    @(negedge clock);
    drive(1'b0, v.amount, v.hold == 0);
    check("busy_rise", s_busy, 1);

    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clock);
      if (s_done || s_error) begin
        nd += int'(s_done);
        ne += int'(s_error);
        fin = 1'b1;
        check("busy_low_at_end", s_busy, 0);
        check("valid_low_at_end", s_valid, 0);
        if (s_error) check("code_at_error", s_code, v.exp_code);
        drive(1'b0, v.amount, 1'b0);
      end else begin
        check("busy_held", s_busy, 1);
        if (s_valid) begin
          if (held < v.hold) begin
            check("held_denom", s_denom, first_den);
            held++;
            drive(v.poke && held == 2, 16'd100, 1'b0);
          end else begin
            drive(1'b0, v.amount, 1'b1);
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL unexpected_note vec%0d: got denom %0d want none", idx, s_denom);
            end else begin
              e = exp_q.pop_front();
              if (s_denom !== e) begin
                bad++;
                $display("FAIL note_denom vec%0d: got %0d want %0d", idx, s_denom, e);
              end
            end
            if (first < 0) first = c;
            last = c;
            acc++;
          end
        end else begin
          check("denom_idle", s_denom, 0);
          drive(1'b0, v.amount, v.hold == 0);
        end
      end
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL timeout vec%0d: got no done/error want one within 200 cycles", idx);
    end

    @(negedge clock);
    check("done_one_cycle", s_done, 0);
    check("error_one_cycle", s_error, 0);
    check("n_done", nd, 1 - v.exp_err);
    check("n_error", ne, v.exp_err);
    check("err_code_held", s_code, v.exp_code);
    check("busy_idle", s_busy, 0);
    check("notes_missing", exp_q.size(), 0);
    check("stock_2000", s_s2000, v.s2000);
    check("stock_500", s_s500, v.s500);
    check("stock_100", s_s100, v.s100);
    if (v.hold == 0 && acc > 1) check("back_to_back", last - first, acc - 1);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{0, 16'd2700,  0, 0, 0, ERR_NONE,   1, 1, 2, 19, 39, 98};
    vecs[1] = '{0, 16'd1550,  0, 0, 1, ERR_AMOUNT, 0, 0, 0, 19, 39, 98};
    vecs[2] = '{0, 16'd0,     0, 0, 1, ERR_AMOUNT, 0, 0, 0, 19, 39, 98};
    vecs[3] = '{0, 16'd20100, 0, 0, 1, ERR_AMOUNT, 0, 0, 0, 19, 39, 98};
    vecs[4] = '{0, 16'd2500,  5, 1, 0, ERR_NONE,   1, 1, 0, 18, 38, 98};
    vecs[5] = '{0, 16'd20000, 0, 0, 0, ERR_NONE,  10, 0, 0,  8, 38, 98};
    vecs[6] = '{1, 16'd900,   0, 0, 1, ERR_STOCK,  0, 0, 0,  0,  1,  2};
    vecs[7] = '{1, 16'd700,   0, 0, 0, ERR_NONE,   0, 1, 2,  0,  0,  0};

    ia.start = 1'b0; ia.amount = '0; ia.note_ack = 1'b0;
    ib.start = 1'b0; ib.amount = '0; ib.note_ack = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    sel_b = 1'b0; #1;
    check_idle_outputs("rst_a", 20, 40, 100);
    sel_b = 1'b1; #1;
    check_idle_outputs("rst_b", 0, 1, 2);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Abort mid-dispense: reset lands one cycle after the first note is taken.
    begin
      bit seen;
      int pulses;
      sel_b = 1'b0;
      seen = 1'b0;
      @(negedge clock);
      drive(1'b1, 16'd4000, 1'b1);
      @(negedge clock);
      drive(1'b0, 16'd4000, 1'b1);
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clock);
        if (s_valid) seen = 1'b1;
      end
      if (!seen) begin
        total++; bad++;
        $display("FAIL abort_no_note: got note_valid=0 want 1 within 20 cycles");
      end
      check("abort_first_denom", s_denom, DEN_2000);
      @(negedge clock);
      check("abort_stock_after_ack", s_s2000, 7);
      reset = 1'b1;
      @(negedge clock);
      check_idle_outputs("abort", 20, 40, 100);
      reset = 1'b0;
      drive(1'b0, 16'd0, 1'b0);
      pulses = 0;
      repeat (5) begin
        @(negedge clock);
        pulses += int'(s_done) + int'(s_error) + int'(s_valid);
      end
      check("abort_quiet", pulses, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
